// File: rtl/mul_arb_ctrl_pkg.sv
// Shared definitions for the multiplier-bank arbitration controller:
// matrix memory geometry, the controller state encoding and the default
// completion timeout derived from the multiplier latency.
`ifndef MATRIX_MEM_DEPTH_BIT
`define MATRIX_MEM_DEPTH_BIT 4
`endif
`ifndef MATRIX_MEM_DATA_HALF_LENGTH
`define MATRIX_MEM_DATA_HALF_LENGTH 8
`endif

package mul_arb_ctrl_pkg;

    localparam int MATRIX_MEM_DEPTH_BIT        = `MATRIX_MEM_DEPTH_BIT;
    localparam int MATRIX_MEM_DATA_HALF_LENGTH = `MATRIX_MEM_DATA_HALF_LENGTH;

    // Twice the nominal multiply latency plus slack before a job is abandoned.
    localparam int TIMEOUT_DEF = 2 * MATRIX_MEM_DATA_HALF_LENGTH + 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first active requester after the
// last granted one; the pointer only moves when a grant is actually taken.
module rr_arbiter #(
    parameter int  NUM_REQ = 2,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_any
);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W:0]   cand;

    // Search from ptr+1 upward with wrap, first active requester wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (IDX_W+1)'(ptr) + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_REQ))
                cand = cand - (IDX_W+1)'(NUM_REQ);
            if (!gnt_any && en && req[cand[IDX_W-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = cand[IDX_W-1:0];
            end
        end
        if (gnt_any)
            gnt[gnt_idx] = 1'b1;
    end

    // Remember the last granted requester; reset value gives requester 0 priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= IDX_W'(NUM_REQ - 1);
        else if (gnt_any)
            ptr <= gnt_idx;
    end

endmodule

// File: rtl/mul_arb_ctrl.sv
// Shares one multiplier among NUM_REQ requesters, one job in flight at a time.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | no job; round-robin grant offered to active requesters
//   ST_ISSUE | start pulse and tag presented to the multiplier
//   ST_BUSY  | waiting for completion, counting towards TIMEOUT
//   ST_RESP  | completion pulse presented to the requesters
module mul_arb_ctrl
    import mul_arb_ctrl_pkg::*;
#(
    parameter int  NUM_REQ = 2,
    parameter int  RD_W    = `MATRIX_MEM_DEPTH_BIT,
    parameter int  TIMEOUT = TIMEOUT_DEF,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_vld,
    input  logic [NUM_REQ*RD_W-1:0] req_rd,
    output logic [NUM_REQ-1:0]      req_rdy,
    output logic [IDX_W-1:0]        op_sel,
    output logic                    mul_vld_in,
    output logic [RD_W-1:0]         mul_rd_in,
    input  logic                    mul_vld_out,
    input  logic [RD_W-1:0]         mul_rd_out,
    output logic                    rsp_vld,
    output logic [IDX_W-1:0]        rsp_id,
    output logic [RD_W-1:0]         rsp_rd,
    output logic                    err_timeout,
    output logic                    err_tag
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [RD_W-1:0]  tag;
    logic [CNT_W-1:0] wait_cnt;
    logic             accept;
    logic [IDX_W-1:0] win_idx;
    logic [RD_W-1:0]  win_tag;

    // Grants are only offered in IDLE and never while reset is held.
    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .en      ((state == ST_IDLE) && !rst),
        .req     (req_vld),
        .gnt     (req_rdy),
        .gnt_idx (win_idx),
        .gnt_any (accept)
    );

    assign win_tag = req_rd[int'(win_idx)*RD_W +: RD_W];
    assign op_sel  = idx;

    // Job sequencing with registered multiplier and response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            idx         <= '0;
            tag         <= '0;
            wait_cnt    <= '0;
            mul_vld_in  <= 1'b0;
            mul_rd_in   <= '0;
            rsp_vld     <= 1'b0;
            rsp_id      <= '0;
            rsp_rd      <= '0;
            err_timeout <= 1'b0;
            err_tag     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        idx        <= win_idx;
                        tag        <= win_tag;
                        mul_vld_in <= 1'b1;
                        mul_rd_in  <= win_tag;
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    mul_vld_in <= 1'b0;
                    mul_rd_in  <= '0;
                    wait_cnt   <= '0;
                    state      <= ST_BUSY;
                end
                ST_BUSY: begin
                    // A completion in the last counted cycle still wins over the timeout.
                    if (mul_vld_out) begin
                        rsp_vld <= 1'b1;
                        rsp_id  <= idx;
                        rsp_rd  <= mul_rd_out;
                        if (mul_rd_out != tag)
                            err_tag <= 1'b1;
                        state   <= ST_RESP;
                    end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        err_timeout <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    rsp_vld <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_arb_ctrl.sv
// Bench for mul_arb_ctrl: a cycle-numbered job model checks every output each
// cycle, while directed scenarios pin the model with literal expectations.
module tb_mul_arb_ctrl;

    localparam int N    = 2;
    localparam int RW   = 4;
    localparam int TO   = 24;
    localparam int HALF = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req_vld = '0;
    logic [N*RW-1:0] req_rd = '0;
    logic [N-1:0]  req_rdy;
    logic [0:0]    op_sel;
    logic          mul_vld_in;
    logic [RW-1:0] mul_rd_in;
    logic          mul_vld_out = 1'b0;
    logic [RW-1:0] mul_rd_out = '0;
    logic          rsp_vld;
    logic [0:0]    rsp_id;
    logic [RW-1:0] rsp_rd;
    logic          err_timeout;
    logic          err_tag;

    int checks   = 0;
    int failures = 0;

    mul_arb_ctrl #(.NUM_REQ(N), .RD_W(RW), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_vld     (req_vld),
        .req_rd      (req_rd),
        .req_rdy     (req_rdy),
        .op_sel      (op_sel),
        .mul_vld_in  (mul_vld_in),
        .mul_rd_in   (mul_rd_in),
        .mul_vld_out (mul_vld_out),
        .mul_rd_out  (mul_rd_out),
        .rsp_vld     (rsp_vld),
        .rsp_id      (rsp_id),
        .rsp_rd      (rsp_rd),
        .err_timeout (err_timeout),
        .err_tag     (err_tag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- multiplier stand-in ----------------
    int mul_mode    = 0;          // 0 echo tag, 1 return tag 3, 2 never complete
    int mul_delay   = HALF + 1;
    bit stray_pulse = 1'b0;

    initial begin
        int pend;
        logic [RW-1:0] pend_rd;
        pend = 0;
        pend_rd = '0;
        forever begin
            @(posedge clk);
            #2;
            mul_vld_out = 1'b0;
            if (stray_pulse) begin
                mul_vld_out = 1'b1;
                mul_rd_out  = 4'd7;
                stray_pulse = 1'b0;
            end
            if (rst) begin
                pend = 0;
            end else if (mul_vld_in && mul_mode != 2) begin
                pend    = mul_delay;
                pend_rd = (mul_mode == 1) ? 4'd3 : mul_rd_in;
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    mul_vld_out = 1'b1;
                    mul_rd_out  = pend_rd;
                end
            end
        end
    end

    // ---------------- behavioural job model ----------------
    int cyc      = 0;
    int rsp_seen = 0;
    bit m_active = 1'b0;
    int m_acc    = 0;
    int m_idx    = 0;
    int m_tag    = 0;
    int m_ptr    = N - 1;
    int m_last   = 0;
    int m_free   = 0;
    int m_rsp_cyc = -1;
    int m_rsp_id = 0;
    int m_rsp_rd = 0;
    bit m_err_tag = 1'b0;
    bit m_err_to  = 1'b0;

    function automatic int rr_pick(input logic [N-1:0] vld, input int last);
        for (int k = 1; k <= N; k++) begin
            if (vld[(last + k) % N])
                return (last + k) % N;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        int  win;
        bit  idle;
        bit  exp_start;
        cyc++;
        if (rsp_vld) rsp_seen++;
        if (rst) begin
            chk("rst_req_rdy",    32'(req_rdy),     32'd0);
            chk("rst_mul_vld_in", 32'(mul_vld_in),  32'd0);
            chk("rst_mul_rd_in",  32'(mul_rd_in),   32'd0);
            chk("rst_rsp_vld",    32'(rsp_vld),     32'd0);
            chk("rst_rsp_id",     32'(rsp_id),      32'd0);
            chk("rst_rsp_rd",     32'(rsp_rd),      32'd0);
            chk("rst_op_sel",     32'(op_sel),      32'd0);
            chk("rst_err_tag",    32'(err_tag),     32'd0);
            chk("rst_err_timeout",32'(err_timeout), 32'd0);
            m_active  = 1'b0;
            m_ptr     = N - 1;
            m_last    = 0;
            m_free    = 0;
            m_rsp_cyc = -1;
            m_err_tag = 1'b0;
            m_err_to  = 1'b0;
        end else begin
            idle = !m_active && (cyc >= m_free);
            win  = idle ? rr_pick(req_vld, m_ptr) : -1;
            chk("req_rdy", 32'(req_rdy), (win >= 0) ? (32'd1 << win) : 32'd0);
            exp_start = m_active && (cyc == m_acc + 1);
            chk("mul_vld_in", 32'(mul_vld_in), 32'(exp_start));
            if (exp_start)
                chk("mul_rd_in", 32'(mul_rd_in), 32'(m_tag));
            chk("rsp_vld", 32'(rsp_vld), 32'(cyc == m_rsp_cyc));
            if (cyc == m_rsp_cyc) begin
                chk("rsp_id", 32'(rsp_id), 32'(m_rsp_id));
                chk("rsp_rd", 32'(rsp_rd), 32'(m_rsp_rd));
            end
            chk("op_sel",      32'(op_sel),      32'(m_last));
            chk("err_tag",     32'(err_tag),     32'(m_err_tag));
            chk("err_timeout", 32'(err_timeout), 32'(m_err_to));

            if (win >= 0) begin
                m_active = 1'b1;
                m_acc    = cyc;
                m_idx    = win;
                m_tag    = int'(req_rd[win*RW +: RW]);
                m_ptr    = win;
                m_last   = win;
            end else if (m_active && cyc >= m_acc + 2) begin
                if (mul_vld_out) begin
                    m_rsp_cyc = cyc + 1;
                    m_rsp_id  = m_idx;
                    m_rsp_rd  = int'(mul_rd_out);
                    if (int'(mul_rd_out) != m_tag) m_err_tag = 1'b1;
                    m_active  = 1'b0;
                    m_free    = cyc + 2;
                end else if (cyc == m_acc + 1 + TO) begin
                    m_err_to = 1'b1;
                    m_active = 1'b0;
                    m_free   = cyc + 1;
                end
            end
        end
    end

    // ---------------- directed scenarios ----------------
    task automatic pulse_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic run_job(input logic [1:0] vld, input logic [3:0] rd0, input logic [3:0] rd1,
                           input int bound, output logic [1:0] rdy0, output logic start,
                           output logic [3:0] start_rd, output bit got, output logic [0:0] id,
                           output logic [3:0] rd, output int lat);
        @(posedge clk); #1;
        req_vld = vld;
        req_rd  = {rd1, rd0};
        @(negedge clk);
        rdy0 = req_rdy;
        @(posedge clk); #1;
        req_vld = '0;
        @(negedge clk);
        start    = mul_vld_in;
        start_rd = mul_rd_in;
        got = 1'b0; id = '0; rd = '0; lat = 0;
        for (int i = 2; i <= bound && !got; i++) begin
            @(negedge clk);
            if (rsp_vld) begin
                got = 1'b1; id = rsp_id; rd = rsp_rd; lat = i;
            end
        end
    endtask

    initial begin
        logic [1:0] rdy0;
        logic       start;
        logic [3:0] start_rd;
        bit         got;
        logic [0:0] id;
        logic [3:0] rd;
        int         lat;
        int         ng, ov, base;
        bit         pend;
        int         gseq [4];

        // reset
        @(negedge clk);
        chk("lit_reset_rdy",  32'(req_rdy),     32'd0);
        chk("lit_reset_etag", 32'(err_tag),     32'd0);
        chk("lit_reset_eto",  32'(err_timeout), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // single request from requester 0, tag 5
        run_job(2'b01, 4'd5, 4'd0, 40, rdy0, start, start_rd, got, id, rd, lat);
        chk("single_rdy",      32'(rdy0),     32'd1);
        chk("single_start",    32'(start),    32'd1);
        chk("single_start_rd", 32'(start_rd), 32'd5);
        chk("single_got",      32'(got),      32'd1);
        chk("single_id",       32'(id),       32'd0);
        chk("single_rd",       32'(rd),       32'd5);
        chk("single_latency",  32'(lat),      32'(1 + HALF + 1 + 1));

        // contention: both requesters held high
        pulse_reset();
        for (int i = 0; i < 4; i++) gseq[i] = 9;
        @(posedge clk); #1;
        req_vld = 2'b11;
        req_rd  = {4'd9, 4'd2};
        ng = 0; ov = 0; pend = 1'b0;
        for (int c = 0; c < 200 && ng < 4; c++) begin
            @(negedge clk);
            if (mul_vld_in) begin if (pend) ov++; pend = 1'b1; end
            if (rsp_vld) pend = 1'b0;
            if ((req_vld & req_rdy) != 2'b00) begin
                gseq[ng] = req_rdy[1] ? 1 : 0;
                ng++;
            end
        end
        @(posedge clk); #1 req_vld = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (mul_vld_in) begin if (pend) ov++; pend = 1'b1; end
            if (rsp_vld) pend = 1'b0;
        end
        chk("cont_grants", 32'(ng),      32'd4);
        chk("cont_g0",     32'(gseq[0]), 32'd0);
        chk("cont_g1",     32'(gseq[1]), 32'd1);
        chk("cont_g2",     32'(gseq[2]), 32'd0);
        chk("cont_g3",     32'(gseq[3]), 32'd1);
        chk("cont_overlap",32'(ov),      32'd0);

        // tag mismatch: multiplier returns 3 for tag 5
        mul_mode = 1;
        run_job(2'b01, 4'd5, 4'd0, 40, rdy0, start, start_rd, got, id, rd, lat);
        mul_mode = 0;
        chk("tag_got",     32'(got),     32'd1);
        chk("tag_rsp_rd",  32'(rd),      32'd3);
        chk("tag_err_tag", 32'(err_tag), 32'd1);

        // timeout: multiplier never completes
        pulse_reset();
        chk("to_tag_cleared", 32'(err_tag), 32'd0);
        mul_mode = 2;
        run_job(2'b10, 4'd0, 4'd6, 40, rdy0, start, start_rd, got, id, rd, lat);
        mul_mode = 0;
        chk("to_rdy",    32'(rdy0),        32'd2);
        chk("to_no_rsp", 32'(got),         32'd0);
        chk("to_flag",   32'(err_timeout), 32'd1);
        run_job(2'b01, 4'd1, 4'd0, 40, rdy0, start, start_rd, got, id, rd, lat);
        chk("to_next_rdy",  32'(rdy0),        32'd1);
        chk("to_next_got",  32'(got),         32'd1);
        chk("to_sticky",    32'(err_timeout), 32'd1);

        // reset during BUSY; pointer would otherwise favour requester 1
        @(posedge clk); #1;
        req_vld = 2'b01;
        req_rd  = {4'd0, 4'd4};
        @(negedge clk);
        chk("mid_grant", 32'(req_rdy), 32'd1);
        @(posedge clk); #1 req_vld = '0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_start", 32'(mul_vld_in),  32'd0);
        chk("mid_rst_rsp",   32'(rsp_vld),     32'd0);
        chk("mid_rst_eto",   32'(err_timeout), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        base = rsp_seen;
        repeat (15) @(negedge clk);
        chk("mid_no_rsp", 32'(rsp_seen - base), 32'd0);
        run_job(2'b11, 4'd8, 4'd10, 40, rdy0, start, start_rd, got, id, rd, lat);
        chk("mid_next_rdy", 32'(rdy0), 32'd1);
        chk("mid_next_id",  32'(id),   32'd0);
        chk("mid_next_rd",  32'(rd),   32'd8);

        // stray completion while idle
        repeat (2) @(negedge clk);
        base = rsp_seen;
        @(posedge clk); #1 stray_pulse = 1'b1;
        repeat (6) @(negedge clk);
        chk("stray_no_rsp", 32'(rsp_seen - base), 32'd0);
        chk("stray_etag",   32'(err_tag),         32'd0);
        chk("stray_eto",    32'(err_timeout),     32'd0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

endmodule
